// File: rtl/tpu_pkg.sv
// Shared types for the systolic TPU datapath: loader FSM states and the A-operand
// element/row types used by memA and its loader.
package tpu_pkg;

  localparam int A_BITS = 8;
  localparam int A_DIM  = 8;

  typedef logic signed [A_BITS-1:0] a_elem_t;
  typedef a_elem_t a_row_t [A_DIM];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ld_state_t;

  // Skewed columns of a DIM x DIM tile need 3*DIM-2 shifts to drain through the array.
  function automatic int default_stream_len(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/mema_loader.sv
// memA front-end: accepts DIM rows over valid/ready, writes them into memA,
// then holds memA in shift mode for STREAM_LEN cycles and pulses done.
module mema_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB    = 8,
  parameter int DIM        = 8,
  parameter int STREAM_LEN = default_stream_len(DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BITS_AB-1:0] in_row [DIM],
  input  logic                      abort,
  output logic                      en,
  output logic                      WrEn,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic [$clog2(DIM)-1:0]    Arow,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(DIM) + 1;
  localparam int SW = $clog2(STREAM_LEN) + 1;
  localparam logic [RW-1:0] ROW_FULL    = RW'(DIM);
  localparam logic [SW-1:0] STREAM_LAST = SW'(STREAM_LEN - 1);

  ld_state_t     state, state_nx;
  logic [RW-1:0] row_cnt, row_cnt_nx;
  logic [SW-1:0] stream_cnt, stream_cnt_nx;
  logic          xfer;
  logic          in_ready_nx, en_nx, wren_nx, done_nx, busy_nx;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      stream_cnt <= '0;
    end else begin
      state      <= state_nx;
      row_cnt    <= row_cnt_nx;
      stream_cnt <= stream_cnt_nx;
    end
  end

  // Next state and next output values; outputs are registered from these below.
  always_comb begin
    state_nx      = state;
    row_cnt_nx    = row_cnt;
    stream_cnt_nx = stream_cnt;
    en_nx         = 1'b0;
    wren_nx       = 1'b0;
    done_nx       = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_nx   = LOAD;
          row_cnt_nx = row_cnt + 1'b1;
          en_nx      = 1'b1;
          wren_nx    = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx   = IDLE;
          row_cnt_nx = '0;
        end else if (row_cnt == ROW_FULL) begin
          // Last write strobe is on the bus now; shifting starts right behind it.
          state_nx      = STREAM;
          row_cnt_nx    = '0;
          stream_cnt_nx = '0;
          en_nx         = 1'b1;
        end else if (xfer) begin
          row_cnt_nx = row_cnt + 1'b1;
          en_nx      = 1'b1;
          wren_nx    = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          state_nx      = IDLE;
          stream_cnt_nx = '0;
        end else if (stream_cnt == STREAM_LAST) begin
          state_nx      = DONE;
          stream_cnt_nx = '0;
          done_nx       = 1'b1;
        end else begin
          stream_cnt_nx = stream_cnt + 1'b1;
          en_nx         = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx = (state_nx == IDLE) || ((state_nx == LOAD) && (row_cnt_nx < ROW_FULL));
    busy_nx     = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      en       <= 1'b0;
      WrEn     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Arow     <= '0;
      Ain      <= '{default: '0};
    end else begin
      in_ready <= in_ready_nx;
      en       <= en_nx;
      WrEn     <= wren_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      if (wren_nx) begin
        Arow <= row_cnt[RW-2:0];
        Ain  <= in_row;
      end
    end
  end

endmodule

// File: tb/tb_mema_loader.sv
// Directed bench for mema_loader (BITS_AB=8, DIM=8, STREAM_LEN=22).
module tb_mema_loader;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_row [8];
  logic              abort;
  logic              en;
  logic              WrEn;
  logic signed [7:0] Ain [8];
  logic [2:0]        Arow;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_bad = 0;

  mema_loader #(.BITS_AB(8), .DIM(8), .STREAM_LEN(22)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .abort(abort), .en(en), .WrEn(WrEn), .Ain(Ain),
    .Arow(Arow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_row(input int base, input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(base + 8 * r + c);
    return v;
  endfunction

  function automatic logic [63:0] ain_packed();
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = Ain[c];
    return v;
  endfunction

  task automatic set_row(input int base, input int r);
    for (int c = 0; c < 8; c++) in_row[c] = 8'(base + 8 * r + c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input string tag, input bit e_en, input bit e_wr,
                            input bit e_done, input bit e_busy, input bit e_rdy);
    chk({tag, ".en"},       64'(en),       64'(e_en));
    chk({tag, ".WrEn"},     64'(WrEn),     64'(e_wr));
    chk({tag, ".done"},     64'(done),     64'(e_done));
    chk({tag, ".busy"},     64'(busy),     64'(e_busy));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_rdy));
  endtask

  task automatic expect_wr(input string tag, input int r, input int base, input bit e_rdy);
    expect_ctl(tag, 1'b1, 1'b1, 1'b0, 1'b1, e_rdy);
    chk({tag, ".Arow"}, 64'(Arow), 64'(r));
    chk({tag, ".Ain"},  ain_packed(), exp_row(base, r));
  endtask

  task automatic expect_zero(input string tag);
    expect_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".Arow"}, 64'(Arow), 64'd0);
    chk({tag, ".Ain"},  ain_packed(), 64'd0);
  endtask

  // Rows first..7 presented back-to-back; in_valid left high when hold is set.
  task automatic load_b2b(input string tag, input int base, input bit hold, input int first);
    for (int r = first; r < 8; r++) begin
      set_row(base, r);
      in_valid = 1'b1;
      tick();
      expect_wr($sformatf("%s.wr%0d", tag, r), r, base, r < 7);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic finish_stream(input string tag, input int n);
    for (int s = 0; s < n; s++) begin
      tick();
      expect_ctl($sformatf("%s.st%0d", tag, s), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    expect_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b1;
    abort    = 1'b0;
    set_row(0, 0);

    // Reset with in_valid asserted
    #2 rst_n = 1'b0;
    #1 expect_zero("rst_async");
    tick();
    tick();
    expect_zero("rst_held");
    rst_n = 1'b1;
    tick();
    expect_ctl("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;

    // Back-to-back load and full stream window
    load_b2b("b2b", 0, 1'b0, 0);
    finish_stream("b2b", 22);

    // Gapped load: one idle cycle after every accepted row
    for (int r = 0; r < 8; r++) begin
      set_row(8, r);
      in_valid = 1'b1;
      tick();
      expect_wr($sformatf("gap.wr%0d", r), r, 8, r < 7);
      in_valid = 1'b0;
      tick();
      if (r < 7) begin
        expect_ctl($sformatf("gap.hole%0d", r), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk($sformatf("gap.hold_arow%0d", r), 64'(Arow), 64'(r));
      end else begin
        expect_ctl("gap.st0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    finish_stream("gap", 21);

    // Abort coincident with the fifth handshake
    for (int r = 0; r < 4; r++) begin
      set_row(16, r);
      in_valid = 1'b1;
      tick();
      expect_wr($sformatf("abl.wr%0d", r), r, 16, 1'b1);
    end
    set_row(16, 4);
    abort = 1'b1;
    tick();
    expect_ctl("abl.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abl.arow_kept", 64'(Arow), 64'd3);
    chk("abl.ain_kept", ain_packed(), exp_row(16, 3));
    in_valid = 1'b0;
    tick();
    expect_ctl("abl.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Restart at row 0; abort held during the IDLE handshake must be ignored
    set_row(-64, 0);
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    expect_wr("idle_abort.wr0", 0, -64, 1'b1);
    abort = 1'b0;
    load_b2b("restart", -64, 1'b0, 1);
    finish_stream("restart", 22);

    // Abort during stream cycle 10
    load_b2b("abs", 0, 1'b0, 0);
    for (int s = 0; s < 11; s++) begin
      tick();
      expect_ctl($sformatf("abs.st%0d", s), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    abort = 1'b1;
    tick();
    expect_ctl("abs.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    abort = 1'b0;
    tick();
    expect_ctl("abs.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Two matrices with in_valid held high throughout
    load_b2b("m0", 0, 1'b1, 0);
    set_row(32, 0);
    finish_stream("m0", 22);
    load_b2b("m1", 32, 1'b0, 0);
    finish_stream("m1", 22);

    // Reset in the middle of a stream window
    load_b2b("mr", 8, 1'b0, 0);
    for (int s = 0; s < 5; s++) tick();
    expect_ctl("mr.st4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1 expect_zero("mr.rst");
    tick();
    rst_n = 1'b1;
    tick();
    expect_ctl("mr.release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mema_loader.md
Name: mema_loader

Overview:
- Front-end sequencer for the A-operand memory of the systolic TPU datapath; sits directly upstream of memA.
- Accepts one matrix row per valid/ready handshake, issues DIM row writes into memA, then holds memA in shift mode for a fixed number of cycles so the skewed columns stream into the MAC array.
- Pulses done when the stream window closes, then accepts the next matrix.

Parameters:
- BITS_AB, 8, width of each signed A element
- DIM, 8, matrix dimension (rows per matrix, elements per row); power of two, >=2
- STREAM_LEN, 3*DIM-2, number of consecutive shift cycles issued after loading

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_row holds a valid row
- in_ready  output  1  loader can accept a row this cycle
- in_row  input  signed [BITS_AB-1:0] x [DIM-1:0]  incoming row, element 0 first
- abort  input  1  synchronous cancel of the current matrix
- en  output  1  memA enable
- WrEn  output  1  memA write enable (1 = write row, 0 = shift)
- Ain  output  signed [BITS_AB-1:0] x [DIM-1:0]  row data to memA
- Arow  output  [$clog2(DIM)-1:0]  row index to memA
- busy  output  1  matrix in progress
- done  output  1  one-cycle pulse at end of stream window

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low. On reset assertion all outputs are 0 immediately (in_ready, en, WrEn, Ain, Arow, busy, done), state is IDLE, and all counters are 0.
- All outputs are registered.
- States:
  - IDLE: in_ready=1. A handshake (in_valid&&in_ready) goes to LOAD.
  - LOAD: in_ready=1 while row_cnt<DIM.
  - STREAM: in_ready=0.
  - DONE: in_ready=0.
- Handshake: a row transfers on a rising edge where in_valid&&in_ready. row_cnt starts at 0 and increments per transfer.
- Write strobe: in the cycle after a transfer, en=1, WrEn=1, Arow=row index (0..DIM-1 in arrival order), Ain=captured row. Otherwise en=0, WrEn=0, and Ain/Arow hold their last value.
- in_valid gaps: no write strobe is issued and the row counter is unchanged.
- in_ready deasserts in the cycle after the DIM-th transfer. No extra row is accepted.
- STREAM entry: the first stream cycle is the cycle immediately after the last write strobe. No idle cycle between them; no overlap with it.
- STREAM: en=1, WrEn=0 for exactly STREAM_LEN consecutive cycles, counted by stream_cnt 0..STREAM_LEN-1.
- DONE: lasts one cycle, done=1, en=0. Next state is IDLE with in_ready=1 again.
- busy: 1 from the cycle after the first transfer through the done cycle inclusive; 0 in IDLE.
- abort:
  - Sampled in LOAD or STREAM.
  - Next cycle: state=IDLE, counters cleared, en=0, WrEn=0, done is not pulsed.
  - A handshake coincident with abort is discarded and not written.
  - abort in IDLE or DONE has no effect.
- Row counter width: $clog2(DIM)+1 bits, so no wrap ambiguity at DIM.
- Stream counter width: $clog2(STREAM_LEN)+1 bits.
- Reset mid-LOAD or mid-STREAM: outputs go to 0 immediately. Partially written memA contents are not the loader's concern, because memA shares rst_n.

Decomposition:
- Shared package tpu_pkg: state enum (IDLE, LOAD, STREAM, DONE), and a localparam helper computing the default STREAM_LEN from DIM.
- Element and row typedefs parameterised on BITS_AB/DIM live in tpu_pkg, alongside memA's.
- Single module. No sub-module needed; the row capture register is inline.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> all outputs 0 and in_ready=0. Release -> in_ready=1 next cycle, no write strobe.
- Back-to-back load, DIM=8, in_valid held high, row r element c = 8r+c -> 8 write strobes with Arow=0..7 and Ain[c]=8r+c. Then 22 cycles of en=1,WrEn=0, then done=1 for 1 cycle. busy high 31 cycles total.
- Gapped load: in_valid toggles 1,0,1,0 -> write strobes only after accepted rows, Arow still sequential 0..7. STREAM starts exactly 1 cycle after the Arow=7 strobe.
- Abort at row 4, coincident with a handshake -> no Arow=4 strobe and no done. Next matrix restarts at Arow=0.
- Abort at stream cycle 10 -> en=0 the next cycle, no done, in_ready=1.
- Two matrices sent back-to-back with in_valid held high through STREAM -> no row accepted during STREAM/DONE. The second matrix's first write strobe appears 2 cycles after done.
